bist_boot_seq: RTL and testbench
================================

# bist_boot_seq

Synthesizable BIST-to-boot sequencer that replaces the bench-level "wait for BIST done, check go/no-go, then enable the core" flow with a parametrised RTL block. It launches `N_CH` BIST engines in parallel or one at a time, and captures each engine's done/pass result. A per-run timeout bounds every run. The block asserts the core's `fetch_enable_o` only when every channel has passed. It sits between the BIST engines and the RI5CY core wrapper.

## Interface
- `N_CH`, 2: number of BIST channels (1..16).
- `SETTLE_CYCLES`, 4: wait cycles between accepted start and channel launch (>= 1).
- `CNT_W`, 16: width of the run-cycle counter and timeout value.
- `SEQUENTIAL`, 0: 0 = launch all channels together; 1 = launch channel 0, then 1, and so on.

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous reset, active high.
- `start_i`  in  1  request; its rising edge (registered) starts a sequence.
- `timeout_i`  in  CNT_W  maximum RUN cycles; 0 disables; latched at accepted start.
- `ch_start_o`  out  N_CH  per-channel start level, held until that channel is captured.
- `ch_done_ni`  in  N_CH  per-channel done, active low.
- `ch_pass_i`  in  N_CH  per-channel go/no-go, valid while the matching `ch_done_ni` is low.
- `busy_o`  out  1  high in SETTLE, RUN and EVAL.
- `done_o`  out  1  high in BOOT and FAIL.
- `pass_o`  out  1  high in BOOT only.
- `timeout_o`  out  1  sticky: the last run ended by timeout.
- `fail_mask_o`  out  N_CH  failed or timed-out channels from the last run.
- `cycles_o`  out  CNT_W  RUN-cycle count of the current or last run; saturates at all-ones.
- `fetch_enable_o`  out  1  core fetch enable.

## Operation
- States: IDLE, SETTLE, RUN, EVAL, BOOT, FAIL. All outputs are registered.
- Reset: state IDLE; every output 0; internal done/fail masks, index, settle counter and `start_i` history are 0.
- Start acceptance: an edge with `start_i`=1 and the previous sample 0 is accepted in IDLE or FAIL.
  - It is ignored in SETTLE, RUN, EVAL and BOOT.
  - On acceptance, clear `fail_mask_o`, `timeout_o` and `cycles_o`; latch `timeout_i`; go to SETTLE.
- SETTLE: count edges. After `SETTLE_CYCLES` edges, go to RUN.
- RUN, parallel mode: `ch_start_o[i]`=1 for every channel not yet captured.
- RUN, sequential mode: only `ch_start_o[idx]`=1, starting at idx=0.
- Capture: at an edge where `ch_start_o[i]`=1 and `ch_done_ni[i]`=0:
  - set done[i], and set `fail_mask_o[i]` to the inverse of `ch_pass_i[i]`;
  - `ch_start_o[i]` drops at the same edge;
  - in sequential mode, idx increments and the next channel's start rises at that edge.
- `ch_done_ni` and `ch_pass_i` of a channel that is not started are ignored.
- Each RUN cycle, `cycles_o` increments, saturating at all-ones.
- Timeout: fires at the edge where the latched timeout is non-zero and `cycles_o` equals timeout−1 with channels still outstanding.
  - All uncaptured channels get their `fail_mask_o` bit set.
  - `timeout_o` is set and all `ch_start_o` drop.
  - The state goes to EVAL.
- Simultaneous capture and timeout on one edge: the captured channel takes its real pass/fail; only the remaining channels are marked timed out.
- Last capture: the edge that completes the done mask moves the state to EVAL.
- EVAL (one cycle): `fail_mask_o`==0 goes to BOOT; otherwise FAIL.
- BOOT: `fetch_enable_o`=1, `done_o`=1, `pass_o`=1. Terminal until reset.
- FAIL: `done_o`=1, `pass_o`=0, `fetch_enable_o`=0. Retry requires a new rising edge on `start_i`.
- Reset asserted mid-sequence: all outputs, including `fetch_enable_o` and `ch_start_o`, clear immediately and asynchronously.

## Timing
- Start edge sampled at edge S → `busy_o`=1 after S.
- `ch_start_o` rises at edge S+`SETTLE_CYCLES`.
- Done low before edge D → capture at D → EVAL from D → BOOT/FAIL outputs after D+1.
- Net latency from last done to `fetch_enable_o`: 2 edges.
- `cycles_o` counts RUN cycles, including the capture or timeout cycle.
- A timeout of T ends RUN after exactly T RUN cycles.
- `start_i` held high is one request; a new sequence needs it to go low and then high again.

## Test plan
- N_CH=2, parallel, timeout 0. Start at edge 10 → `ch_start_o`=2'b11 at edge 14. Ch0 done/pass at 20 and ch1 done/pass at 25 → `fetch_enable_o`=1, `pass_o`=1 after edge 26, `cycles_o`=12, `fail_mask_o`=0.
- Parallel, ch1 reports pass=0 → FAIL, `fail_mask_o`=2'b10, `fetch_enable_o` stays 0. A new `start_i` edge restarts and clears the mask.
- Sequential, N_CH=3 → exactly one `ch_start_o` bit high at a time (001, 010, 100). The next channel starts on the previous channel's capture edge.
- Timeout 8, ch1 never completes → RUN lasts 8 cycles, `timeout_o`=1, `fail_mask_o`=2'b10, state FAIL.
- Ch0 capture on the timeout edge → ch0 keeps its real result and only ch1 is marked failed. `ch_done_ni` pulsed low before launch → ignored.
- `rst_i` asserted in RUN and in BOOT → every output is 0 immediately. After release, `start_i` held high from reset does not start a run until it goes low and then high again.

Source files
------------

// File: rtl/bist_boot_seq.sv
// BIST-to-boot sequencer: launches N_CH BIST engines (together or one by one),
// captures each go/no-go result under an optional run timeout, then enables core fetch.
module bist_boot_seq #(
  parameter int N_CH          = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int SEQUENTIAL    = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] timeout_i,
  output logic [N_CH-1:0]  ch_start_o,
  input  logic [N_CH-1:0]  ch_done_ni,
  input  logic [N_CH-1:0]  ch_pass_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [N_CH-1:0]  fail_mask_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             fetch_enable_o
);

  localparam int IDX_W = $clog2(N_CH + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_EVAL   = 3'd3,
    ST_BOOT   = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t           r_state, w_state;
  logic             r_start_low;
  logic [SET_W-1:0] r_settle_cnt, w_settle_cnt;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [N_CH-1:0]  r_done_mask, w_done_mask;
  logic [CNT_W-1:0] r_tmo, w_tmo;
  logic [N_CH-1:0]  r_ch_start, w_ch_start;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic             r_timeout, w_timeout;
  logic [N_CH-1:0]  r_fail_mask, w_fail_mask;
  logic [CNT_W-1:0] r_cycles, w_cycles;
  logic             r_fetch_en, w_fetch_en;

  logic             w_accept;
  logic [N_CH-1:0]  w_cap;
  logic [N_CH-1:0]  w_cap_done;
  logic [N_CH-1:0]  w_cap_fail;
  logic             w_all_done;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_cnt_inc;

  function automatic logic [N_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) begin
      v[i] = (IDX_W'(i) == idx);
    end
    return v;
  endfunction

  // r_start_low remembers "start_i was low last edge"; clear at reset so a level held from reset is not a request
  assign w_accept   = start_i & r_start_low;
  assign w_cap      = r_ch_start & ~ch_done_ni;
  assign w_cap_done = r_done_mask | w_cap;
  assign w_cap_fail = r_fail_mask | (w_cap & ~ch_pass_i);
  assign w_all_done = &w_cap_done;
  assign w_cnt_inc  = (r_cycles == CNT_MAX) ? r_cycles : (r_cycles + CNT_ONE);
  assign w_tmo_hit  = (r_tmo != {CNT_W{1'b0}}) && (r_cycles >= (r_tmo - CNT_ONE));

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_settle_cnt = r_settle_cnt;
    w_idx        = r_idx;
    w_done_mask  = r_done_mask;
    w_tmo        = r_tmo;
    w_ch_start   = r_ch_start;
    w_timeout    = r_timeout;
    w_fail_mask  = r_fail_mask;
    w_cycles     = r_cycles;

    case (r_state)
      ST_IDLE, ST_FAIL: begin
        if (w_accept) begin
          w_state      = ST_SETTLE;
          w_settle_cnt = {SET_W{1'b0}};
          w_idx        = {IDX_W{1'b0}};
          w_done_mask  = {N_CH{1'b0}};
          w_tmo        = timeout_i;
          w_timeout    = 1'b0;
          w_fail_mask  = {N_CH{1'b0}};
          w_cycles     = {CNT_W{1'b0}};
        end else begin
          w_state = r_state;
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state  = ST_RUN;
          w_cycles = CNT_ONE;
          if (SEQUENTIAL != 0) begin
            w_ch_start = onehot({IDX_W{1'b0}});
          end else begin
            w_ch_start = {N_CH{1'b1}};
          end
        end else begin
          w_settle_cnt = r_settle_cnt + SET_W'(1);
        end
      end
      ST_RUN: begin
        w_cycles    = w_cnt_inc;
        w_done_mask = w_cap_done;
        w_fail_mask = w_cap_fail;
        if (|w_cap) begin
          w_idx = r_idx + IDX_W'(1);
        end else begin
          w_idx = r_idx;
        end
        // A capture on the timeout edge keeps its real result; only the rest are marked
        if (w_all_done) begin
          w_state    = ST_EVAL;
          w_ch_start = {N_CH{1'b0}};
        end else if (w_tmo_hit) begin
          w_state     = ST_EVAL;
          w_ch_start  = {N_CH{1'b0}};
          w_timeout   = 1'b1;
          w_fail_mask = w_cap_fail | ~w_cap_done;
        end else if (SEQUENTIAL != 0) begin
          w_ch_start = onehot(w_idx);
        end else begin
          w_ch_start = ~w_cap_done;
        end
      end
      ST_EVAL: begin
        if (r_fail_mask == {N_CH{1'b0}}) begin
          w_state = ST_BOOT;
        end else begin
          w_state = ST_FAIL;
        end
      end
      ST_BOOT: begin
        w_state = ST_BOOT;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_busy     = (w_state == ST_SETTLE) || (w_state == ST_RUN) || (w_state == ST_EVAL);
    w_done     = (w_state == ST_BOOT) || (w_state == ST_FAIL);
    w_pass     = (w_state == ST_BOOT);
    w_fetch_en = (w_state == ST_BOOT);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_start_low  <= 1'b0;
      r_settle_cnt <= {SET_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_done_mask  <= {N_CH{1'b0}};
      r_tmo        <= {CNT_W{1'b0}};
      r_ch_start   <= {N_CH{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_fail_mask  <= {N_CH{1'b0}};
      r_cycles     <= {CNT_W{1'b0}};
      r_fetch_en   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_start_low  <= ~start_i;
      r_settle_cnt <= w_settle_cnt;
      r_idx        <= w_idx;
      r_done_mask  <= w_done_mask;
      r_tmo        <= w_tmo;
      r_ch_start   <= w_ch_start;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pass       <= w_pass;
      r_timeout    <= w_timeout;
      r_fail_mask  <= w_fail_mask;
      r_cycles     <= w_cycles;
      r_fetch_en   <= w_fetch_en;
    end
  end

  assign ch_start_o     = r_ch_start;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign pass_o         = r_pass;
  assign timeout_o      = r_timeout;
  assign fail_mask_o    = r_fail_mask;
  assign cycles_o       = r_cycles;
  assign fetch_enable_o = r_fetch_en;

endmodule

// File: tb/tb_bist_boot_seq.sv
// Self-checking bench: a parallel 2-channel instance and a sequential 3-channel instance
// driven by emulated BIST engines, checked against a run-level outcome model.
module tb_bist_boot_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [15:0] tmo;

  logic [1:0]  a_cs, a_dn, a_pi, a_fm;
  logic        a_busy, a_done, a_pass, a_to, a_fe;
  logic [15:0] a_cyc;

  logic [2:0]  b_cs, b_dn, b_pi, b_fm;
  logic        b_busy, b_done, b_pass, b_to, b_fe;
  logic [15:0] b_cyc;

  bist_boot_seq #(.N_CH(2), .SETTLE_CYCLES(4), .CNT_W(16), .SEQUENTIAL(0)) u_par (
    .clk_i(clk), .rst_i(rst), .start_i(start), .timeout_i(tmo),
    .ch_start_o(a_cs), .ch_done_ni(a_dn), .ch_pass_i(a_pi),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_to),
    .fail_mask_o(a_fm), .cycles_o(a_cyc), .fetch_enable_o(a_fe)
  );

  bist_boot_seq #(.N_CH(3), .SETTLE_CYCLES(4), .CNT_W(16), .SEQUENTIAL(1)) u_seq (
    .clk_i(clk), .rst_i(rst), .start_i(start), .timeout_i(tmo),
    .ch_start_o(b_cs), .ch_done_ni(b_dn), .ch_pass_i(b_pi),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
    .fail_mask_o(b_fm), .cycles_o(b_cyc), .fetch_enable_o(b_fe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Engine config: lat = edges from launch to capture (0 = never completes), pv = reported pass
  int lat[3];
  bit pv[3];
  int cnt_a[3];
  int cnt_b[3];
  bit noise   = 1'b0;
  bit pre_low = 1'b0;

  typedef struct {
    int         t;
    int         l0;
    int         l1;
    bit         p0;
    bit         p1;
    int         cyc;
    logic [1:0] mask;
    bit         to;
    bit         ok;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic engine_step(input logic started, input int l, input bit p, inout int cnt,
                             output logic dn, output logic pi);
    if (started) begin
      cnt++;
      if (l != 0 && cnt >= l) begin
        dn = 1'b0;
        pi = p;
      end else begin
        dn = 1'b1;
        pi = 1'($urandom_range(0, 1));
      end
    end else begin
      cnt = 0;
      if (pre_low) begin
        dn = 1'b0;
        pi = 1'b0;
      end else if (noise) begin
        dn = 1'($urandom_range(0, 1));
        pi = 1'($urandom_range(0, 1));
      end else begin
        dn = 1'b1;
        pi = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic d, p;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      engine_step(a_cs[i], lat[i], pv[i], cnt_a[i], d, p);
      a_dn[i] = d;
      a_pi[i] = p;
    end
    for (int i = 0; i < 3; i++) begin
      engine_step(b_cs[i], lat[i], pv[i], cnt_b[i], d, p);
      b_dn[i] = d;
      b_pi[i] = p;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Raises start so the next edge (S) accepts it; returns just after S
  task automatic launch(input int t);
    tmo   = 16'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit need_b);
    int k = 0;
    while (!(a_done && (!need_b || b_done)) && k < 500) begin
      tick();
      k++;
    end
    chk("wait_done", 32'(a_done && (!need_b || b_done)), 32'd1);
  endtask

  // Outcome of one run from launch-relative capture offsets
  function automatic void model(input int n, input bit seq, input int t,
                                output int cyc, output logic [2:0] mask, output bit to);
    int off[3];
    int acc = 0;
    int fin = 0;
    mask = 3'b000;
    to   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (seq) begin
        acc    = (acc < 0 || lat[i] == 0) ? -1 : acc + lat[i];
        off[i] = acc;
      end else begin
        off[i] = (lat[i] == 0) ? -1 : lat[i];
      end
      if (fin >= 0) fin = (off[i] < 0) ? -1 : ((off[i] > fin) ? off[i] : fin);
    end
    if (fin >= 0 && (t == 0 || fin + 1 <= t)) begin
      cyc = fin + 1;
      for (int i = 0; i < n; i++) mask[i] = !pv[i];
    end else begin
      cyc = t;
      to  = 1'b1;
      for (int i = 0; i < n; i++) mask[i] = (off[i] >= 0 && off[i] <= t - 1) ? !pv[i] : 1'b1;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    int          cyc_e;
    logic [2:0]  mask_e;
    bit          to_e;
    int          cum;
    logic [2:0]  exp_cs;

    tbl[0] = '{0,  6, 11, 1'b1, 1'b1, 12, 2'b00, 1'b0, 1'b1};
    tbl[1] = '{0,  3,  5, 1'b1, 1'b0,  6, 2'b10, 1'b0, 1'b0};
    tbl[2] = '{8,  2,  0, 1'b1, 1'b1,  8, 2'b10, 1'b1, 1'b0};
    tbl[3] = '{8,  7,  0, 1'b1, 1'b1,  8, 2'b10, 1'b1, 1'b0};
    tbl[4] = '{8,  7,  7, 1'b1, 1'b1,  8, 2'b00, 1'b0, 1'b1};
    tbl[5] = '{5,  0,  0, 1'b1, 1'b1,  5, 2'b11, 1'b1, 1'b0};
    tbl[6] = '{4,  3,  9, 1'b0, 1'b1,  4, 2'b11, 1'b1, 1'b0};
    tbl[7] = '{20, 4,  4, 1'b0, 1'b1,  5, 2'b01, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; tmo = 16'd0;
    a_dn = 2'b11; a_pi = 2'b00; b_dn = 3'b111; b_pi = 3'b000;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 1; pv[i] = 1'b1; cnt_a[i] = 0; cnt_b[i] = 0;
    end
    #2;
    chk("reset_outputs_a", 32'({a_cs, a_busy, a_done, a_pass, a_to, a_fm, a_cyc, a_fe}), 32'd0);
    chk("reset_outputs_b", 32'({b_cs, b_busy, b_done, b_pass, b_to, b_fm, b_fe}), 32'd0);

    // Exact-timing run; unstarted channels hold done low with pass=0 to prove they are ignored
    pre_low = 1'b1;
    lat[0] = 6; lat[1] = 11; lat[2] = 1;
    do_reset();
    launch(0);
    chk("h1_busy_after_S", 32'(a_busy), 32'd1);
    chk("h1_no_launch_at_S", 32'(a_cs), 32'd0);
    repeat (3) tick();
    chk("h1_no_launch_S3", 32'(a_cs), 32'd0);
    tick();
    chk("h1_launch_S4", 32'(a_cs), 32'b11);
    repeat (6) tick();
    chk("h1_ch0_captured", 32'(a_cs), 32'b10);
    repeat (5) tick();
    chk("h1_eval_busy", 32'(a_busy), 32'd1);
    chk("h1_eval_no_fetch", 32'(a_fe), 32'd0);
    tick();
    chk("h1_fetch", 32'(a_fe), 32'd1);
    chk("h1_pass", 32'(a_pass), 32'd1);
    chk("h1_cycles", 32'(a_cyc), 32'd12);
    chk("h1_mask", 32'(a_fm), 32'd0);
    start = 1'b1;
    tick();
    tick();
    chk("h1_boot_ignores_start_fe", 32'(a_fe), 32'd1);
    chk("h1_boot_ignores_start_cyc", 32'(a_cyc), 32'd12);
    pre_low = 1'b0;

    // Table of parallel runs
    for (int v = 0; v < 8; v++) begin
      lat[0] = tbl[v].l0; lat[1] = tbl[v].l1; lat[2] = 1;
      pv[0] = tbl[v].p0; pv[1] = tbl[v].p1; pv[2] = 1'b1;
      do_reset();
      launch(tbl[v].t);
      wait_done(1'b0);
      chk($sformatf("tbl%0d_cycles", v), 32'(a_cyc), 32'(tbl[v].cyc));
      chk($sformatf("tbl%0d_mask", v), 32'(a_fm), 32'(tbl[v].mask));
      chk($sformatf("tbl%0d_timeout", v), 32'(a_to), 32'(tbl[v].to));
      chk($sformatf("tbl%0d_pass", v), 32'(a_pass), 32'(tbl[v].ok));
      chk($sformatf("tbl%0d_fetch", v), 32'(a_fe), 32'(tbl[v].ok));
    end

    // FAIL then retry clears the mask
    lat[0] = 3; lat[1] = 5; lat[2] = 1;
    pv[0] = 1'b1; pv[1] = 1'b0; pv[2] = 1'b1;
    do_reset();
    launch(0);
    wait_done(1'b0);
    chk("h2_fail_mask", 32'(a_fm), 32'b10);
    chk("h2_fail_fetch", 32'(a_fe), 32'd0);
    pv[1] = 1'b1;
    start = 1'b1;
    tick();
    chk("h2_retry_mask_clr", 32'(a_fm), 32'd0);
    chk("h2_retry_cyc_clr", 32'(a_cyc), 32'd0);
    chk("h2_retry_busy", 32'({a_busy, a_done}), 32'b10);
    start = 1'b0;
    wait_done(1'b0);
    chk("h2_retry_fetch", 32'(a_fe), 32'd1);
    chk("h2_retry_mask", 32'(a_fm), 32'd0);

    // Sequential: exactly one start bit, handed over on the capture edge
    lat[0] = 3; lat[1] = 2; lat[2] = 4;
    pv[0] = 1'b1; pv[1] = 1'b1; pv[2] = 1'b1;
    do_reset();
    launch(0);
    repeat (3) tick();
    for (int k = 0; k <= 9; k++) begin
      tick();
      cum = 0;
      exp_cs = 3'b000;
      for (int j = 0; j < 3; j++) begin
        if (exp_cs == 3'b000 && k < cum + lat[j]) exp_cs[j] = 1'b1;
        cum += lat[j];
      end
      chk($sformatf("h3_seq_start_k%0d", k), 32'(b_cs), 32'(exp_cs));
    end
    wait_done(1'b1);
    chk("h3_seq_pass", 32'(b_pass), 32'd1);
    chk("h3_seq_cycles", 32'(b_cyc), 32'd10);

    // Async reset in RUN and in BOOT; start held high through reset is not a request
    lat[0] = 6; lat[1] = 11; lat[2] = 2;
    do_reset();
    launch(0);
    repeat (6) tick();
    rst = 1'b1;
    #2;
    chk("h5_rst_run_a", 32'({a_cs, a_busy, a_done, a_pass, a_to, a_fm, a_cyc, a_fe}), 32'd0);
    chk("h5_rst_run_b", 32'({b_cs, b_busy, b_fe}), 32'd0);
    lat[0] = 1; lat[1] = 1; lat[2] = 1;
    do_reset();
    launch(0);
    wait_done(1'b1);
    chk("h5_boot_fetch", 32'({a_fe, b_fe}), 32'b11);
    rst   = 1'b1;
    start = 1'b1;
    #2;
    chk("h5_rst_boot_a", 32'({a_cs, a_busy, a_done, a_pass, a_to, a_fm, a_cyc, a_fe}), 32'd0);
    chk("h5_rst_boot_b", 32'({b_cs, b_done, b_fe}), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("h5_held_start_ignored", 32'({a_busy, b_busy}), 32'd0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("h5_new_edge_starts", 32'({a_busy, b_busy}), 32'b11);
    start = 1'b0;

    // Randomized runs on both instances against the outcome model
    noise = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int t;
      t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 30));
      for (int i = 0; i < 3; i++) begin
        lat[i] = (t == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
        pv[i]  = 1'($urandom_range(0, 3) != 0);
      end
      do_reset();
      launch(t);
      wait_done(1'b1);
      model(2, 1'b0, t, cyc_e, mask_e, to_e);
      chk($sformatf("rnd%0d_par_cycles", r), 32'(a_cyc), 32'(cyc_e));
      chk($sformatf("rnd%0d_par_mask", r), 32'(a_fm), 32'(mask_e[1:0]));
      chk($sformatf("rnd%0d_par_timeout", r), 32'(a_to), 32'(to_e));
      chk($sformatf("rnd%0d_par_fetch", r), 32'(a_fe), 32'(mask_e[1:0] == 2'b00));
      model(3, 1'b1, t, cyc_e, mask_e, to_e);
      chk($sformatf("rnd%0d_seq_cycles", r), 32'(b_cyc), 32'(cyc_e));
      chk($sformatf("rnd%0d_seq_mask", r), 32'(b_fm), 32'(mask_e));
      chk($sformatf("rnd%0d_seq_timeout", r), 32'(b_to), 32'(to_e));
      chk($sformatf("rnd%0d_seq_fetch", r), 32'(b_fe), 32'(mask_e == 3'b000));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
